trace_dump_ctrl: RTL

//  Sequences readout of a captured trace from the shared sample RAM after capture completes.

---
 rtl/scope_pkg.sv | 16 +
 rtl/ram_port_arb.sv | 29 ++
 rtl/trace_dump_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/scope_pkg.sv
// Shared types for the scope trace path: dump sequencer states and sample depth.
package scope_pkg;

  localparam int SMPL_DEPTH = 512;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    RD,
    LAT,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/ram_port_arb.sv
// Combinational mux for the single sample-RAM port; the capture engine always wins.
module ram_port_arb #(
  parameter int AW = 9
) (
  input  logic          cap_en,
  input  logic          cap_we,
  input  logic [AW-1:0] cap_addr,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr
);

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    if (cap_en) begin
      ram_en   = 1'b1;
      ram_we   = cap_we;
      ram_addr = cap_addr;
    end else if (rd_req) begin
      ram_en   = 1'b1;
      ram_addr = rd_addr;
    end
  end

endmodule

// File: rtl/trace_dump_ctrl.sv
// Streams a captured circular trace oldest-to-newest from the sample RAM to the UART link.
// Define TRACE_DUMP_HDR_EN to prefix each dump with a 2-byte trace_end header.
module trace_dump_ctrl
  import scope_pkg::*;
#(
  parameter int AW    = 9,
  parameter int DEPTH = SMPL_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump_req,
  input  logic          dump_abort,
  input  logic          cap_done,
  input  logic [AW-1:0] trace_end,
  input  logic          cap_en,
  input  logic          cap_we,
  input  logic [AW-1:0] cap_addr,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_rdata,
  output logic [7:0]    tx_data,
  output logic          tx_vld,
  input  logic          tx_rdy,
  output logic          busy,
  output logic          dump_done,
  output logic          clr_cap_done
);

  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  dump_state_t   state_reg, state_next;
  logic [AW-1:0] rd_addr_reg, rd_addr_next;
  logic [AW:0]   byte_cnt_reg, byte_cnt_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          tx_vld_reg, tx_vld_next;

`ifdef TRACE_DUMP_HDR_EN
  // rd_addr holds trace_end+1 untouched until the first sample, so the latched
  // trace_end is recovered from it rather than stored twice.
  logic [AW-1:0] hdr_end;
  assign hdr_end = rd_addr_reg - AW'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rd_addr_reg  <= '0;
      byte_cnt_reg <= '0;
      tx_data_reg  <= '0;
      tx_vld_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_addr_reg  <= rd_addr_next;
      byte_cnt_reg <= byte_cnt_next;
      tx_data_reg  <= tx_data_next;
      tx_vld_reg   <= tx_vld_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rd_addr_next  = rd_addr_reg;
    byte_cnt_next = byte_cnt_reg;
    tx_data_next  = tx_data_reg;
    tx_vld_next   = tx_vld_reg;
    if (dump_abort) begin
      state_next  = IDLE;
      tx_vld_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dump_req && cap_done) begin
            rd_addr_next  = trace_end + AW'(1);
            byte_cnt_next = '0;
`ifdef TRACE_DUMP_HDR_EN
            tx_data_next  = 8'(trace_end >> 8);
            tx_vld_next   = 1'b1;
            state_next    = HDR_HI;
`else
            state_next    = RD;
`endif
          end
        end
`ifdef TRACE_DUMP_HDR_EN
        HDR_HI: begin
          if (tx_rdy) begin
            tx_data_next = hdr_end[7:0];
            state_next   = HDR_LO;
          end
        end
        HDR_LO: begin
          if (tx_rdy) begin
            tx_vld_next = 1'b0;
            state_next  = RD;
          end
        end
`endif
        RD: begin
          // The capture engine owns the port this cycle; retry with rd_addr held.
          if (!cap_en) state_next = LAT;
        end
        LAT: begin
          tx_data_next = ram_rdata;
          tx_vld_next  = 1'b1;
          state_next   = SEND;
        end
        SEND: begin
          if (tx_rdy) begin
            tx_vld_next   = 1'b0;
            byte_cnt_next = byte_cnt_reg + (AW+1)'(1);
            rd_addr_next  = rd_addr_reg + AW'(1);
            state_next    = (byte_cnt_reg == LAST_CNT) ? DONE : RD;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next  = IDLE;
          tx_vld_next = 1'b0;
        end
      endcase
    end
  end

  ram_port_arb #(
    .AW(AW)
  ) u_arb (
    .cap_en   (cap_en),
    .cap_we   (cap_we),
    .cap_addr (cap_addr),
    .rd_req   (state_reg == RD),
    .rd_addr  (rd_addr_reg),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr)
  );

  assign tx_data      = tx_data_reg;
  assign tx_vld       = tx_vld_reg;
  assign busy         = (state_reg != IDLE);
  assign dump_done    = (state_reg == DONE);
  assign clr_cap_done = (state_reg == DONE);

endmodule
